cus19_crypto_block_ctrl: RTL
============================

Name: cus19_crypto_block_ctrl

Overview:
- Memory-to-memory sequencer for the IE-stage crypto unit.
- Accepts one command (mode, source, destination, length). For each byte: read data memory, transform it through the crypto datapath, write the result back.
- Shares the data-memory port with the CPU through an external arbiter using a req/gnt handshake. Frees the core from issuing per-byte encrypt/decrypt instructions.

Parameters:
- ADDR_W, 8, data-memory byte-address width; also the width of the length field.
- KEY, 8'hA5, crypto key forwarded to the crypto datapath.
- CHAIN_IV, 8'h00, initial chaining value; used only when CUS19_CRYPTO_CHAIN_EN is defined.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  controller idle; command accepted when cmd_valid&cmd_ready.
- cmd_mode  in  1  1=encrypt, 0=decrypt.
- cmd_src  in  ADDR_W  first source byte address.
- cmd_dst  in  ADDR_W  first destination byte address.
- cmd_len  in  ADDR_W  byte count; 0 is a legal empty command.
- mem_req  out  1  memory access request.
- mem_gnt  in  1  arbiter grant; access occurs in a cycle with mem_req&mem_gnt.
- mem_we  out  1  1=write, 0=read.
- mem_addr  out  ADDR_W  access address.
- mem_wdata  out  8  write data.
- mem_rdata  in  8  read data, valid the cycle after a granted read.
- busy  out  1  command in progress (state!=IDLE).
- done  out  1  one-cycle pulse at command completion.

Behaviour:
- Transform:
  - encrypt: E(x) = rotl3(x) ^ KEY.
  - decrypt: D(x) = rotr3(x ^ KEY).
  - Computed combinationally from the captured read byte.
- Reset (async, immediate): state=IDLE, cmd_ready=1, busy=0, done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, all pointers/counters=0.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- IDLE:
  - cmd_ready=1.
  - On accept, latch mode, src_ptr, dst_ptr and remaining=cmd_len.
  - Go to DONE if cmd_len==0, else RD_REQ.
  - cmd_valid while not in IDLE is ignored (cmd_ready=0).
- RD_REQ: mem_req=1, mem_we=0, mem_addr=src_ptr. Held stable until mem_gnt; on gnt go to RD_WAIT.
- RD_WAIT: mem_req=0. Register result_reg <= E/D(mem_rdata). Go to WR_REQ.
- WR_REQ:
  - mem_req=1, mem_we=1, mem_addr=dst_ptr, mem_wdata=result_reg. Held stable until mem_gnt.
  - On gnt: src_ptr+1, dst_ptr+1, remaining-1.
  - Go to DONE if remaining was 1, else RD_REQ.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE.
- Latency with mem_gnt tied high:
  - N bytes: done asserted 3N+1 cycles after the accept edge.
  - Length 0: done asserted 1 cycle after the accept edge, with no memory access.
- Pointers wrap modulo 2^ADDR_W (0xFF+1 -> 0x00). No error is flagged.
- Ordering:
  - Strictly byte-sequential, ascending, each read before its write.
  - src==dst gives a correct in-place transform.
  - Overlapping ranges follow this ordering exactly.
- Grant withheld: the FSM stalls in RD_REQ/WR_REQ with outputs stable, with no timeout.
- Reset mid-command: aborts immediately. Bytes already written remain; no done pulse.

Optional Feature:
- Macro: CUS19_CRYPTO_CHAIN_EN.
- Defined: CBC-style chaining.
  - chain_reg loads CHAIN_IV on command accept and updates in RD_WAIT.
  - encrypt: out = E(in ^ chain); chain <= out.
  - decrypt: out = D(in) ^ chain; chain <= in.
- Undefined: independent per-byte (ECB) transform. No chain_reg; CHAIN_IV unused.
- Timing is identical in both builds.

Decomposition:
- Package cus19_crypto_pkg:
  - state enum (IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE).
  - MODE_ENC=1 / MODE_DEC=0 constants.
  - Default key constant 8'hA5.
- Sub-module: instantiate the existing cus19_cryptography_unit for the E/D transform, with start tied high and mode from the latched mode.
- The FSM, pointers and chaining stay in this module.

Test Plan:
- Encrypt, len=1, src=0x10=0x01, dst=0x20, gnt=1 -> mem[0x20]=0xAD; done at accept+4; busy high for cycles 1..4.
- Decrypt in place, len=3, src=dst=0x40, data {0xAD,0x5A,0xA5} -> {0x01,0xFF,0x00}; done at accept+10.
- Wrap: encrypt, len=2, src=0xFF, dst=0x00 -> reads 0xFF then 0x00; writes 0x00 then 0x01; pointers wrap without error.
- len=0 -> no mem_req ever; done pulse at accept+1; cmd_ready back to 1 next cycle.
- Grant stalls of 0-3 random cycles on each access -> mem_addr/mem_we/mem_wdata stable while mem_req&!mem_gnt; results match golden model. Assert rst during WR_REQ -> mem_req=0 immediately, no done pulse, idle state values restored.
- With CUS19_CRYPTO_CHAIN_EN, IV=0x00: encrypt {0x01,0x01} -> {0xAD,0xC0}; decrypt {0xAD,0xC0} -> {0x01,0x01}. Without the macro: encrypt {0x01,0x01} -> {0xAD,0xAD}.

Source files
------------

// File: rtl/cus19_crypto_pkg.sv
// Shared types and constants for the cus19 crypto block sequencer.
package cus19_crypto_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic       MODE_ENC    = 1'b1;
    localparam logic       MODE_DEC    = 1'b0;
    localparam logic [7:0] DEFAULT_KEY = 8'hA5;

    function automatic logic [7:0] rotl3(input logic [7:0] x);
        return {x[4:0], x[7:5]};
    endfunction

    function automatic logic [7:0] rotr3(input logic [7:0] x);
        return {x[2:0], x[7:3]};
    endfunction

endpackage

// File: rtl/cus19_crypto_block_ctrl_if.sv
// Command and data-memory handshake bundle for the crypto block sequencer.
interface cus19_crypto_block_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_mode;
    logic [ADDR_W-1:0] cmd_src;
    logic [ADDR_W-1:0] cmd_dst;
    logic [ADDR_W-1:0] cmd_len;
    logic              mem_req;
    logic              mem_gnt;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport master (
        input  cmd_valid, cmd_mode, cmd_src, cmd_dst, cmd_len, mem_gnt, mem_rdata,
        output cmd_ready, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output cmd_valid, cmd_mode, cmd_src, cmd_dst, cmd_len, mem_gnt, mem_rdata,
        input  cmd_ready, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cus19_crypto_block_ctrl_unit.sv
// cus19_cryptography_unit: combinational per-byte encrypt/decrypt datapath.
module cus19_cryptography_unit
    import cus19_crypto_pkg::*;
#(
    parameter logic [7:0] KEY = DEFAULT_KEY
) (
    input  logic       start,
    input  logic       mode,
    input  logic [7:0] din,
    output logic [7:0] dout
);
    // Encrypt rotates then whitens; decrypt undoes it in reverse order
    always_comb begin
        dout = 8'h00;
        if (start) begin
            if (mode == MODE_ENC) begin
                dout = rotl3(din) ^ KEY;
            end else begin
                dout = rotr3(din ^ KEY);
            end
        end else begin
            dout = 8'h00;
        end
    end
endmodule

// File: rtl/cus19_crypto_block_ctrl.sv
// Memory-to-memory byte crypto sequencer sharing the data-memory port via req/gnt.
// Define CUS19_CRYPTO_CHAIN_EN for CBC-style chaining; the default build is per-byte ECB.
module cus19_crypto_block_ctrl
    import cus19_crypto_pkg::*;
#(
    parameter int         ADDR_W   = 8,
    parameter logic [7:0] KEY      = DEFAULT_KEY,
    parameter logic [7:0] CHAIN_IV = 8'h00
) (
    input  logic                      clk,
    input  logic                      rst,
    cus19_crypto_block_ctrl_if.master bus,
    output logic                      busy,
    output logic                      done
);
    localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_r, state_s;
    logic              mode_r, mode_s;
    logic [ADDR_W-1:0] src_r, src_s;
    logic [ADDR_W-1:0] dst_r, dst_s;
    logic [ADDR_W-1:0] rem_r, rem_s;
    logic [7:0]        result_r, result_s;
    logic              cmd_ready_r, busy_r, done_r, mem_req_r, mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
    logic [7:0]        mem_wdata_r, mem_wdata_s;
    logic              accept_s;
    logic [7:0]        chain_cur_s, unit_in_s, unit_out_s, xform_s;

    assign accept_s = (state_r == IDLE) && bus.cmd_valid;

`ifdef CUS19_CRYPTO_CHAIN_EN
    logic [7:0] chain_r, chain_s;

    // Chain value: IV on accept, advanced once per byte in RD_WAIT
    always_comb begin
        chain_s = chain_r;
        if (accept_s) begin
            chain_s = CHAIN_IV;
        end else if (state_r == RD_WAIT) begin
            chain_s = (mode_r == MODE_ENC) ? xform_s : bus.mem_rdata;
        end else begin
            chain_s = chain_r;
        end
    end

    // Chain register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_r <= 8'h00;
        end else begin
            chain_r <= chain_s;
        end
    end

    assign chain_cur_s = chain_r;
`else
    // Nothing is carried between bytes, so the IV folds away to zero.
    assign chain_cur_s = CHAIN_IV & 8'h00;
`endif

    assign unit_in_s = (mode_r == MODE_ENC) ? (bus.mem_rdata ^ chain_cur_s) : bus.mem_rdata;
    assign xform_s   = (mode_r == MODE_ENC) ? unit_out_s : (unit_out_s ^ chain_cur_s);

    cus19_cryptography_unit #(
        .KEY (KEY)
    ) u_unit (
        .start (1'b1),
        .mode  (mode_r),
        .din   (unit_in_s),
        .dout  (unit_out_s)
    );

    // Next-state, pointer and result computation
    always_comb begin
        state_s  = state_r;
        mode_s   = mode_r;
        src_s    = src_r;
        dst_s    = dst_r;
        rem_s    = rem_r;
        result_s = result_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    mode_s  = bus.cmd_mode;
                    src_s   = bus.cmd_src;
                    dst_s   = bus.cmd_dst;
                    rem_s   = bus.cmd_len;
                    state_s = (bus.cmd_len == PTR_ZERO) ? DONE : RD_REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            RD_REQ: begin
                if (bus.mem_gnt) begin
                    state_s = RD_WAIT;
                end else begin
                    state_s = RD_REQ;
                end
            end
            RD_WAIT: begin
                result_s = xform_s;
                state_s  = WR_REQ;
            end
            WR_REQ: begin
                if (bus.mem_gnt) begin
                    src_s   = src_r + PTR_ONE;
                    dst_s   = dst_r + PTR_ONE;
                    rem_s   = rem_r - PTR_ONE;
                    state_s = (rem_r == PTR_ONE) ? DONE : RD_REQ;
                end else begin
                    state_s = WR_REQ;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Bus address/data for the upcoming state; held while a request waits for grant
    always_comb begin
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        case (state_s)
            RD_REQ: begin
                mem_addr_s = src_s;
            end
            WR_REQ: begin
                mem_addr_s  = dst_s;
                mem_wdata_s = result_s;
            end
            default: begin
                mem_addr_s  = mem_addr_r;
                mem_wdata_s = mem_wdata_r;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            mode_r      <= MODE_DEC;
            src_r       <= PTR_ZERO;
            dst_r       <= PTR_ZERO;
            rem_r       <= PTR_ZERO;
            result_r    <= 8'h00;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= PTR_ZERO;
            mem_wdata_r <= 8'h00;
        end else begin
            state_r     <= state_s;
            mode_r      <= mode_s;
            src_r       <= src_s;
            dst_r       <= dst_s;
            rem_r       <= rem_s;
            result_r    <= result_s;
            cmd_ready_r <= (state_s == IDLE);
            busy_r      <= (state_s != IDLE);
            done_r      <= (state_s == DONE);
            mem_req_r   <= (state_s == RD_REQ) || (state_s == WR_REQ);
            mem_we_r    <= (state_s == WR_REQ);
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
        end
    end

    assign bus.cmd_ready = cmd_ready_r;
    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign busy          = busy_r;
    assign done          = done_r;

endmodule
